// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared widths for the 5-stage pipeline boundaries
// and the skid-buffer state encoding used by pipe_stage_reg.
package riscv_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // IF/ID: instr + pc
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 2 * XLEN;

    // ID/EX: rs1 + rs2 + rd + rs1_val + rs2_val + imm + pc
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 3 * REG_ADDR_W + 4 * XLEN;

    // EX/MEM: rd + alu_result + store_data + pc
    localparam int EXMEM_CTRL_W = 6;
    localparam int EXMEM_DATA_W = REG_ADDR_W + 3 * XLEN;

    // MEM/WB: rd + alu_result + read_mem_data + pc
    localparam int MEMWB_CTRL_W = 4;
    localparam int MEMWB_DATA_W = REG_ADDR_W + 3 * XLEN;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BUSY  = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: W-bit up counter that sticks at all-ones.
// Ports: clk, rst (async, active-high), en (increment), cnt (value).
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked stage register with flush and stall counter.
// Ports: clk, rst (async, active-high), flush; in_valid/in_ready/in_ctrl/
// in_data upstream; out_valid/out_ready/out_ctrl/out_data downstream;
// stall_cnt = saturating count of back-pressure cycles.
// Build option: PIPE_SKID_EN adds a skid entry and a registered in_ready.
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic              in_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_data = main_data_q;
    // A bubble must never carry live control bits downstream.
    assign out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};

`ifdef PIPE_SKID_EN

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              in_ready_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_d = BUSY;
                BUSY: begin
                    if (out_ready && !in_fire)
                        state_d = EMPTY;
                    else if (!out_ready && in_fire)
                        state_d = FULL;
                end
                FULL: if (out_ready) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Registered so out_ready never reaches in_ready combinationally.
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (!flush) begin
            if (state_q == FULL) begin
                if (out_ready) begin
                    main_ctrl_q <= skid_ctrl_q;
                    main_data_q <= skid_data_q;
                end
            end else if (in_fire) begin
                if (state_q == EMPTY || out_ready) begin
                    main_ctrl_q <= in_ctrl;
                    main_data_q <= in_data;
                end else begin
                    skid_ctrl_q <= in_ctrl;
                    skid_data_q <= in_data;
                end
            end
        end
    end

`else

    logic valid_q;

    assign out_valid = valid_q;
    assign in_ready  = ~valid_q | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
        end
    end

    // Payload only moves on an accepted beat, so a stalled beat stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else if (in_fire && !flush) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
        end
    end

`endif

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (out_valid & ~out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg.
// Works with or without PIPE_SKID_EN defined.
module tb_pipe_stage_reg;

    localparam int CW = 4;
    localparam int DW = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [CW+DW-1:0] sb[$];

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .CNT_W  (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on negedge; accepted beats are queued just before
    // the next posedge, when in_ready has settled.
    task automatic drive(input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d, input logic ordy,
                         input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #4;
        if (fl)
            sb.delete();
        else if (v && in_ready)
            sb.push_back({c, d});
    endtask

    // Monitor: compares every delivered beat against the scoreboard.
    initial begin
        logic [CW+DW-1:0] exp_beat;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got %0h expected none",
                                 {out_ctrl, out_data});
                    end else begin
                        exp_beat = sb.pop_front();
                        chk("out_beat", 32'({out_ctrl, out_data}),
                            32'(exp_beat));
                    end
                end
                if (!out_valid)
                    chk("bubble_ctrl", 32'(out_ctrl), 32'h0);
            end
        end
    end

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;

        // Stream 8 beats at full rate
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'hF, 16'(i), 1'b1, 1'b0);
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            if (i > 0)
                chk("stream_latency", 32'(out_data), 32'(i - 1));
        end
        drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
        chk("stream_out_data", 32'(out_data), 32'h7);
        chk("stream_stall", 32'(stall_cnt), 32'h0);

        // Back-pressure for 5 cycles
        drive(1'b1, 4'hF, 16'h20, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 4'h3, 16'h21, 1'b0, 1'b0);
            chk("bp_hold_data", 32'(out_data), 32'h20);
            chk("bp_hold_ctrl", 32'(out_ctrl), 32'hF);
`ifdef PIPE_SKID_EN
            if (k == 1)
                chk("bp_skid_accept", 32'(in_ready), 32'h1);
`endif
            if (k >= 2)
                chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
        chk("bp_stall_cnt", 32'(stall_cnt), 32'h5);
        repeat (3) drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
        chk("bp_drained", 32'(sb.size()), 32'h0);

        // Flush with a beat incoming
        drive(1'b1, 4'h5, 16'h0A, 1'b0, 1'b0);
        drive(1'b1, 4'h6, 16'h0B, 1'b0, 1'b0);
        drive(1'b1, 4'h7, 16'h0C, 1'b0, 1'b1);
        drive(1'b0, 4'hF, 16'h0, 1'b0, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("flush_stall_cnt", 32'(stall_cnt), 32'h7);
        repeat (2) drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);

        // Bubbles with live-looking control bits
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'hF, 16'h33, 1'b1, 1'b0);
            chk("gate_out_ctrl", 32'(out_ctrl), 32'h0);
            chk("gate_out_valid", 32'(out_valid), 32'h0);
        end

        // Saturation: 20 stall cycles on a 4-bit counter
        drive(1'b1, 4'h9, 16'h55, 1'b0, 1'b0);
        drive(1'b1, 4'hA, 16'h56, 1'b0, 1'b0);
        repeat (19) drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hF);
        chk("sat_hold_data", 32'(out_data), 32'h55);
        drive(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
        chk("sat_stall_hold", 32'(stall_cnt), 32'hF);
`ifdef PIPE_SKID_EN
        chk("sat_full_in_ready", 32'(in_ready), 32'h0);
`endif

        // Async reset between edges while stalled
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("arst_out_data", 32'(out_data), 32'h0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        // Traffic resumes right after reset
        for (int i = 0; i < 3; i++)
            drive(1'b1, 4'hC, 16'(16'h70 + i), 1'b1, 1'b0);
        drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
        chk("post_rst_data", 32'(out_data), 32'h72);
        drive(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
        chk("post_rst_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the 5-stage RISC-V core. It replaces the fixed per-stage latches (IF/ID … MEM/WB) with one reusable block. The block carries a control field and a data field, supports valid/ready back-pressure and a synchronous flush, and keeps a back-pressure cycle counter. One instance sits at each stage boundary. Instances are configured by width only.

## Interface
Parameters:
- CTRL_W, 4: width of control field (e.g. MemtoReg, jmp, regWE); forced to zero when no valid beat.
- DATA_W, 101: width of payload (e.g. rd + alu_result + read_mem_data + pc = 5+32+32+32).
- CNT_W, 16: width of stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  held beat valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bits; all-zero whenever out_valid=0.
- out_data  out  DATA_W  payload; value is don't-care when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

## Operation
- Transfer rule: a beat moves on a port when valid & ready are both high at a rising edge. Beats are never duplicated, dropped, or reordered, except by flush.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid empty. in_ready=1 in both configurations.
- out_ctrl = ctrl register AND out_valid. This guarantees a bubble never writes the register file or memory.
- Flush has priority over everything. On the edge where flush=1, all entries are invalidated: out_valid=0 and the skid is empty next cycle. An input beat offered in that cycle is discarded, even if in_ready=1. stall_cnt is not affected by flush.
- stall_cnt increments on every edge where out_valid=1 and out_ready=0. It holds at all-ones (2^CNT_W−1) and only rst clears it.
- Skid state machine (PIPE_SKID_EN defined):
  - EMPTY: in_valid moves to BUSY.
  - BUSY: out fire with no in fire moves to EMPTY. Both firing stays in BUSY with main reloaded. In fire with out stalled moves to FULL (beat goes into skid).
  - FULL: out fire moves the skid into main and the state goes to BUSY. No input is accepted in FULL.
  - flush moves any state to EMPTY.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- Full throughput (1 beat/cycle) while out_ready=1.
- With PIPE_SKID_EN: in_ready is a flop output, equal to 1 unless in FULL. There is no combinational path from out_ready to in_ready.
- Without PIPE_SKID_EN: in_ready = ~out_valid | out_ready, a combinational path.
- When out_valid=1 and out_ready=0, out_ctrl and out_data must stay stable until the transfer or a flush.
- rst asserted mid-transfer clears everything immediately, without waiting for a clock edge. The first accept is possible on the first edge after rst deasserts.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid buffer (main + skid registers) and registered in_ready, for timing closure on long stall chains.
- PIPE_SKID_EN undefined: single entry and combinational in_ready. The skid registers and FULL state are not generated. The transfer behaviour seen at the ports is identical; only in_ready timing differs.

## Structure
- Shared package riscv_pipe_pkg holds:
  - default width constants: REG_ADDR_W=5, XLEN=32, MEMWB_CTRL_W, MEMWB_DATA_W, and the corresponding constants for the other stage boundaries;
  - the skid state encoding: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
- One sub-module, pipe_sat_counter (CNT_W-wide, increment-enable, saturating), instantiated for stall_cnt.
- Callers concatenate their fields into in_ctrl/in_data. This block has no knowledge of field meaning.

## Test plan
- Reset then stream: rst=1 for 2 cycles, then 8 beats with in_data=0..7, in_ctrl=4'hF, out_ready=1 → out_data 0..7 one cycle later each, in_ready=1 throughout, stall_cnt=0.
- Back-pressure: out_ready=0 for 5 cycles while a beat is held → out_data held stable, stall_cnt=5. With PIPE_SKID_EN, one extra beat is accepted, then in_ready=0, and both beats drain in order once out_ready=1.
- Flush with a beat incoming: FULL state holding data 0xA, 0xB, then flush=1 together with in_valid=1, in_data=0xC → next cycle out_valid=0, out_ctrl=0, and 0xC is never output.
- Bubble gating: in_valid=0 with in_ctrl=4'hF for 3 cycles → out_ctrl=0 in every cycle.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with a beat held → stall_cnt stops at 15 and stays there.
- Async reset mid-stall: rst pulsed between edges while in FULL → all outputs zero immediately, in_ready=1.
